// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // 0 = CPU data port, 1 = loader/DMA port
    typedef logic master_id_t;

    // Wide enough for a beat index up to 14 (BURST_MAX up to 15)
    localparam int CNT_W = 4;

    function automatic arb_state_t own_state(input master_id_t m);
        return m ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational master picker used when leaving IDLE.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the
// master that did not win last time; otherwise a tie always goes to master 0.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       m0_valid,
    input  logic       m1_valid,
    input  master_id_t last_grant,
    output master_id_t pick
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Single requester wins outright; a tie is resolved by the build option.
    always_comb begin
        pick = 1'b0;
        if (m0_valid && m1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick = ~last_grant;
`else
            pick = 1'b0;
`endif
        end else if (m1_valid) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single combinational-read data memory.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects the tie-break in arb_pick.
//
//   state | meaning
//   IDLE  | nobody owns the port; arbitration happens here, no transfer
//   OWN0  | master 0 owns the port; its valid cycles are transfers
//   OWN1  | master 1 owns the port; its valid cycles are transfers
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst,

    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [1:0]            m0_type_i,
    input  logic                  m0_sign_i,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [1:0]            m1_type_i,
    input  logic                  m1_sign_i,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [1:0]            mem_type_o,
    output logic                  mem_sign_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] beat_cnt;
    master_id_t       last_grant;
    master_id_t       pick;

    logic sel1;
    logic xfer0;
    logic xfer1;
    logic cur_valid;
    logic oth_valid;
    logic burst_done;

    arb_pick u_pick (
        .m0_valid   (m0_valid_i),
        .m1_valid   (m1_valid_i),
        .last_grant (last_grant),
        .pick       (pick)
    );

    assign sel1       = (state == OWN1);
    assign xfer0      = (state == OWN0) && m0_valid_i;
    assign xfer1      = (state == OWN1) && m1_valid_i;
    assign cur_valid  = sel1 ? m1_valid_i : m0_valid_i;
    assign oth_valid  = sel1 ? m0_valid_i : m1_valid_i;
    assign burst_done = (beat_cnt == BEAT_LAST);

    assign m0_ready_o = (state == OWN0);
    assign m1_ready_o = (state == OWN1);

    // Memory port follows the owner; write enable is gated so idle cycles never write.
    assign mem_addr_o  = sel1 ? m1_addr_i  : m0_addr_i;
    assign mem_wdata_o = sel1 ? m1_wdata_i : m0_wdata_i;
    assign mem_type_o  = sel1 ? m1_type_i  : m0_type_i;
    assign mem_sign_o  = sel1 ? m1_sign_i  : m0_sign_i;
    assign mem_we_o    = (xfer0 && m0_we_i) || (xfer1 && m1_we_i);

    // Ownership FSM: burst limit only bites when the other master is waiting.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid_i || m1_valid_i) begin
                        state      <= own_state(pick);
                        last_grant <= pick;
                        beat_cnt   <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (cur_valid && !(oth_valid && burst_done)) begin
                        if (!burst_done) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (oth_valid) begin
                        state      <= own_state(~sel1);
                        last_grant <= ~sel1;
                        beat_cnt   <= '0;
                    end else begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Read return: capture the combinational memory value one cycle after a read transfer.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
        end else begin
            m0_rvalid_o <= xfer0 && !m0_we_i;
            m1_rvalid_o <= xfer1 && !m1_we_i;
            if (xfer0 && !m0_we_i) begin
                m0_rdata_o <= mem_rdata_i;
            end
            if (xfer1 && !m1_we_i) begin
                m1_rdata_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences,
// and randomized traffic against a tenure-counting reference model.
module tb_mem_arbiter;

    localparam int BM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m0_we, m0_sign, m0_rvalid;
    logic [1:0]  m0_type;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready, m1_we, m1_sign, m1_rvalid;
    logic [1:0]  m1_type;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_sign;
    logic [1:0]  mem_type;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    assign mem_rdata = mem_val(mem_addr);

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_MAX(BM)) dut (
        .clk_i(clk), .rst(rst),
        .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_wdata_i(m0_wdata), .m0_type_i(m0_type), .m0_sign_i(m0_sign),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_wdata_i(m1_wdata), .m1_type_i(m1_type), .m1_sign_i(m1_sign),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_type_o(mem_type), .mem_sign_o(mem_sign), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_type = 0; m0_sign = 0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_type = 0; m1_sign = 0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1;
        idle_inputs();
        next_cycle();
        rst = 0;
    endtask

    typedef struct {
        logic v0, v1, we0, we1;
        logic r0, r1, mwe, rv0, rv1;
    } vec_t;

    vec_t tbl [10];

    // Reference model state: who owns the port and how many beats this tenure has moved.
    int          owner;
    int          beats;
    int          last_g;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;

    initial begin
        rst = 1;
        idle_inputs();

        //            v0 v1 we0 we1  r0 r1 mwe rv0 rv1
        tbl[0] = '{ 0, 0, 0, 0,   0, 0, 0,  0, 0 };
        tbl[1] = '{ 1, 0, 1, 0,   0, 0, 0,  0, 0 };
        tbl[2] = '{ 1, 0, 1, 0,   1, 0, 1,  0, 0 };
        tbl[3] = '{ 0, 0, 0, 0,   1, 0, 0,  0, 0 };
        tbl[4] = '{ 0, 1, 0, 1,   0, 0, 0,  0, 0 };
        tbl[5] = '{ 0, 1, 0, 1,   0, 1, 1,  0, 0 };
        tbl[6] = '{ 0, 1, 0, 0,   0, 1, 0,  0, 0 };
        tbl[7] = '{ 1, 0, 1, 0,   0, 1, 0,  0, 1 };
        tbl[8] = '{ 1, 0, 1, 0,   1, 0, 1,  0, 0 };
        tbl[9] = '{ 0, 0, 0, 0,   1, 0, 0,  0, 0 };

        // Reset state
        do_reset();
        settle();
        chk("rst_ready0", m0_ready, 0);
        chk("rst_ready1", m1_ready, 0);
        chk("rst_rvalid0", m0_rvalid, 0);
        chk("rst_rvalid1", m1_rvalid, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rdata1", m1_rdata, 0);
        chk("rst_mem_we", mem_we, 0);

        // Directed table; first row runs in the same cycle as the reset-state checks
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            m0_valid = tbl[i].v0; m0_we = tbl[i].we0; m0_addr = 32'h100 + i;
            m1_valid = tbl[i].v1; m1_we = tbl[i].we1; m1_addr = 32'h200 + i;
            settle();
            chk($sformatf("tbl%0d_ready0", i), m0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), m1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].mwe);
            chk($sformatf("tbl%0d_rvalid0", i), m0_rvalid, tbl[i].rv0);
            chk($sformatf("tbl%0d_rvalid1", i), m1_rvalid, tbl[i].rv1);
        end

        // m0 single read at 0x10 held valid: ready in cycle 2, data in cycle 3
        do_reset();
        m0_valid = 1; m0_we = 0; m0_addr = 32'h10;
        settle();
        chk("rd10_c1_ready0", m0_ready, 0);
        next_cycle();
        settle();
        chk("rd10_c2_ready0", m0_ready, 1);
        chk("rd10_c2_addr", mem_addr, 32'h10);
        chk("rd10_c2_we", mem_we, 0);
        next_cycle();
        m0_valid = 0;
        settle();
        chk("rd10_c3_rvalid0", m0_rvalid, 1);
        chk("rd10_c3_rdata0", m0_rdata, mem_val(32'h10));
        next_cycle();
        settle();
        chk("rd10_c4_rvalid0", m0_rvalid, 0);

        // Both masters streaming reads: master 0 first, then alternate every BM beats
        do_reset();
        m0_valid = 1; m1_valid = 1; m0_addr = 32'h400; m1_addr = 32'h800;
        settle();
        chk("alt_idle_ready0", m0_ready, 0);
        chk("alt_idle_ready1", m1_ready, 0);
        for (int k = 0; k < 4 * BM; k++) begin
            int exp_own, prev_own;
            next_cycle();
            m0_addr = 32'h400 + k; m1_addr = 32'h800 + k;
            settle();
            exp_own  = (k / BM) % 2;
            prev_own = ((k - 1) / BM) % 2;
            chk($sformatf("alt%0d_ready0", k), m0_ready, exp_own == 0);
            chk($sformatf("alt%0d_ready1", k), m1_ready, exp_own == 1);
            chk($sformatf("alt%0d_rvalid0", k), m0_rvalid, k > 0 && prev_own == 0);
            chk($sformatf("alt%0d_rvalid1", k), m1_rvalid, k > 0 && prev_own == 1);
        end

        // m1 alone for 10 writes: never loses the port
        do_reset();
        m1_valid = 1; m1_we = 1;
        settle();
        begin
            int n_xfer;
            n_xfer = 0;
            for (int k = 0; k < 10; k++) begin
                next_cycle();
                m1_wdata = 32'hD000 + k;
                settle();
                if (m1_ready && mem_we && mem_wdata == 32'hD000 + k) n_xfer++;
            end
            chk("m1_solo_beats", n_xfer, 10);
        end

        // Tie from IDLE after master 0 was served
        do_reset();
        m0_valid = 1; m0_we = 1;
        next_cycle();
        next_cycle();
        m0_valid = 0;
        next_cycle();
        m0_valid = 1; m1_valid = 1;
        settle();
        chk("tie_idle_ready0", m0_ready, 0);
        next_cycle();
        settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("tie_rr_ready1", m1_ready, 1);
`else
        chk("tie_fixed_ready0", m0_ready, 1);
`endif

        // Reset during an m0 read burst
        do_reset();
        m0_valid = 1; m0_we = 0; m0_addr = 32'h40;
        next_cycle();
        next_cycle();
        rst = 1;
        settle();
        chk("rstmid_xfer_ready0", m0_ready, 1);
        next_cycle();
        rst = 0; m0_we = 1;
        settle();
        chk("rstmid_ready0", m0_ready, 0);
        chk("rstmid_rvalid0", m0_rvalid, 0);
        chk("rstmid_mem_we", mem_we, 0);

        // Randomized traffic against the reference model
        do_reset();
        owner = -1; beats = 0; last_g = 1; ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
        for (int c = 0; c < 1500; c++) begin
            logic xf, wv, rd0, rd1;
            int   oth, pk;
            if (c > 0) next_cycle();
            rst      = ($urandom_range(0, 99) == 0);
            m0_valid = ($urandom_range(0, 9) < 7);
            m1_valid = ($urandom_range(0, 9) < 6);
            m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            m0_type = 2'($urandom_range(0, 3)); m1_type = 2'($urandom_range(0, 3));
            m0_sign = $urandom_range(0, 1); m1_sign = $urandom_range(0, 1);
            settle();

            xf = (owner == 0 && m0_valid) || (owner == 1 && m1_valid);
            wv = xf && (owner == 0 ? m0_we : m1_we);
            chk("rnd_ready0", m0_ready, owner == 0);
            chk("rnd_ready1", m1_ready, owner == 1);
            chk("rnd_mem_we", mem_we, wv);
            if (xf) begin
                chk("rnd_mem_addr", mem_addr, owner == 0 ? m0_addr : m1_addr);
                chk("rnd_mem_type", mem_type, owner == 0 ? m0_type : m1_type);
                chk("rnd_mem_sign", mem_sign, owner == 0 ? m0_sign : m1_sign);
                if (wv) chk("rnd_mem_wdata", mem_wdata, owner == 0 ? m0_wdata : m1_wdata);
            end
            chk("rnd_rvalid0", m0_rvalid, ev0);
            chk("rnd_rvalid1", m1_rvalid, ev1);
            if (ev0) chk("rnd_rdata0", m0_rdata, ed0);
            if (ev1) chk("rnd_rdata1", m1_rdata, ed1);

            if (rst) begin
                owner = -1; beats = 0; last_g = 1; ev0 = 0; ev1 = 0;
            end else begin
                rd0 = xf && owner == 0 && !m0_we;
                rd1 = xf && owner == 1 && !m1_we;
                ev0 = rd0; ev1 = rd1;
                if (rd0) ed0 = mem_val(m0_addr);
                if (rd1) ed1 = mem_val(m1_addr);
                if (owner < 0) begin
                    if (m0_valid || m1_valid) begin
                        if (m0_valid && m1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            pk = 1 - last_g;
`else
                            pk = 0;
`endif
                        end else begin
                            pk = m0_valid ? 0 : 1;
                        end
                        owner = pk; last_g = pk; beats = 0;
                    end
                end else begin
                    oth = 1 - owner;
                    if (xf) begin
                        beats++;
                        if ((oth == 0 ? m0_valid : m1_valid) && beats >= BM) begin
                            owner = oth; last_g = oth; beats = 0;
                        end
                    end else if (oth == 0 ? m0_valid : m1_valid) begin
                        owner = oth; last_g = oth; beats = 0;
                    end else begin
                        owner = -1; beats = 0;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
